// File: rtl/cpu_pkg.sv
// Shared control definitions: ALU op codes, RV32I opcodes, FSM states, instruction classes.
// Types and constants only; no timing or backpressure of its own.
package cpu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_ILL
    } instr_cls_t;

    // Returns {legal, alu_op}; alt selects SUB/SRA over ADD/SRL.
    function automatic logic [4:0] decode_alu_funct(input logic [2:0] funct3, input logic alt);
        logic [4:0] res;
        res = {1'b1, ALU_AND};
        case (funct3)
            3'b000:  res[3:0] = alt ? ALU_SUB : ALU_ADD;
            3'b111:  res[3:0] = ALU_AND;
            3'b110:  res[3:0] = ALU_OR;
            3'b100:  res[3:0] = ALU_XOR;
            3'b010:  res[3:0] = ALU_SLT;
            3'b001:  res[3:0] = ALU_SLL;
            3'b101:  res[3:0] = alt ? ALU_SRA : ALU_SRL;
            default: res[4]   = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller-to-datapath bundle; master is the controller, slave is memory/ALU/regfile side.
// Pure wiring: no latency, mem_ready is the only stall input.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        pc_write;
    logic        pc_sel;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instr, zero, mem_ready,
        output alu_op, alu_src, mem_read, mem_write, mem_to_reg,
               reg_write, pc_write, pc_sel, illegal, state
    );

    modport slave (
        output instr, zero, mem_ready,
        input  alu_op, alu_src, mem_read, mem_write, mem_to_reg,
               reg_write, pc_write, pc_sel, illegal, state
    );
endinterface

// File: rtl/alu_decode.sv
// Combinational map from the latched instruction to ALU op, operand select, class and illegal.
// Zero latency, no backpressure.
module alu_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        illegal,
    output instr_cls_t  cls
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] r_res;
    logic [4:0] i_res;
    logic       unused_ir_bits;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    // Immediates reuse ir[30] as data, so only shifts may treat it as an op modifier.
    assign r_res = decode_alu_funct(funct3, ir[30]);
    assign i_res = decode_alu_funct(funct3, (funct3 == 3'b101) & ir[30]);

    always_comb begin
        alu_op  = ALU_AND;
        alu_src = 1'b0;
        cls     = CLS_ILL;
        case (opcode)
            OP_RTYPE: begin
                alu_op  = r_res[3:0];
                alu_src = 1'b0;
                if (r_res[4]) cls = CLS_ALU;
            end
            OP_ITYPE: begin
                alu_op  = i_res[3:0];
                alu_src = 1'b1;
                if (i_res[4]) cls = CLS_ALU;
            end
            OP_LW: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                if (funct3 == 3'b010) cls = CLS_LW;
            end
            OP_SW: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                if (funct3 == 3'b010) cls = CLS_SW;
            end
            OP_BEQ: begin
                alu_op  = ALU_SUB;
                alu_src = 1'b0;
                if (funct3 == 3'b000) cls = CLS_BEQ;
            end
            default: cls = CLS_ILL;
        endcase
    end

    assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer; 2-5 cycles per instruction plus one per MEM stall.
// Stalls in MEM while mem_ready is low, holding the access strobe.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic [3:0]  dec_op;
    logic        dec_src;
    logic        dec_illegal;
    instr_cls_t  dec_cls;

    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        pc_write;
    logic        pc_sel;
    logic        illegal;

    alu_decode u_alu_decode (
        .ir      (ir_q),
        .alu_op  (dec_op),
        .alu_src (dec_src),
        .illegal (dec_illegal),
        .cls     (dec_cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        alu_op     = ALU_AND;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op  = dec_op;
                alu_src = dec_src;
                case (dec_cls)
                    CLS_BEQ: begin
                        // zero reflects this cycle's SUB of rs1/rs2, so the branch resolves here.
                        pc_write = 1'b1;
                        pc_sel   = bus.zero;
                        state_d  = ST_FETCH;
                    end
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_read  = (dec_cls == CLS_LW);
                mem_write = (dec_cls == CLS_SW);
                if (bus.mem_ready) begin
                    if (dec_cls == CLS_LW) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (dec_cls == CLS_LW);
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.alu_op     = alu_op;
    assign bus.alu_src    = alu_src;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_sel     = pc_sel;
    assign bus.illegal    = illegal;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs queued at issue, compared as the DUT steps.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] op;
        logic       src;
        logic       rd;
        logic       wr;
        logic       m2r;
        logic       rw;
        logic       pcw;
        logic       pcs;
        logic       ill;
    } obs_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        zero;
        logic        mrdy;
    } drv_t;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_ILL} kind_t;

    obs_t sb_q[$];
    drv_t drv_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic obs_t idle(input logic [2:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic drv_t rand_drv();
        drv_t d;
        d.instr = $urandom;
        d.zero  = rbit();
        d.mrdy  = rbit();
        return d;
    endfunction

    task automatic check_now(input string tag, input obs_t e);
        obs_t o;
        o = {bus.state, bus.alu_op, bus.alu_src, bus.mem_read, bus.mem_write,
             bus.mem_to_reg, bus.reg_write, bus.pc_write, bus.pc_sel, bus.illegal};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input obs_t e, input drv_t d);
        sb_q.push_back(e);
        drv_q.push_back(d);
    endtask

    task automatic run_queue(input string tag);
        int   cyc;
        drv_t d;
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            d = drv_q.pop_front();
            bus.instr     = d.instr;
            bus.zero      = d.zero;
            bus.mem_ready = d.mrdy;
            #1;
            check_now($sformatf("%s_c%0d", tag, cyc), sb_q.pop_front());
            cyc++;
        end
    endtask

    // Queue the full expected cycle sequence of one instruction, then step through it.
    task automatic issue(input string tag, input logic [31:0] ins, input kind_t k,
                         input logic [3:0] op, input logic src, input logic z, input int stalls);
        obs_t e;
        drv_t d;
        d = rand_drv();
        d.instr = ins;
        push(idle(3'd0), d);
        e = idle(3'd1);
        if (k == K_ILL) begin
            e.ill = 1'b1;
            e.pcw = 1'b1;
        end
        push(e, rand_drv());
        if (k != K_ILL) begin
            e = idle(3'd2);
            e.op  = op;
            e.src = src;
            d = rand_drv();
            if (k == K_BEQ) begin
                e.pcw  = 1'b1;
                e.pcs  = z;
                d.zero = z;
            end
            push(e, d);
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i <= stalls; i++) begin
                    e = idle(3'd3);
                    e.rd = (k == K_LW);
                    e.wr = (k == K_SW);
                    d = rand_drv();
                    d.mrdy = (i == stalls);
                    if (k == K_SW && i == stalls) e.pcw = 1'b1;
                    push(e, d);
                end
            end
            if (k == K_R || k == K_I || k == K_LW) begin
                e = idle(3'd4);
                e.rw  = 1'b1;
                e.pcw = 1'b1;
                e.m2r = (k == K_LW);
                push(e, rand_drv());
            end
        end
        run_queue(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;
        drv_t d;
        rst_n         = 1'b0;
        bus.instr     = 32'hFFFF_FFFF;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        #2;
        check_now("reset_async", idle(3'd0));
        @(posedge clk);
        #1;
        check_now("reset_held", idle(3'd0));
        rst_n = 1'b1;

        issue("add",    32'h002081B3, K_R,   4'b0010, 1'b0, 1'b0, 0);
        issue("sub",    32'h402081B3, K_R,   4'b0110, 1'b0, 1'b0, 0);
        issue("or",     32'h0020E1B3, K_R,   4'b0001, 1'b0, 1'b0, 0);
        issue("srai",   32'h4020D193, K_I,   4'b1010, 1'b1, 1'b0, 0);
        issue("addi30", 32'h40008093, K_I,   4'b0010, 1'b1, 1'b0, 0);
        issue("lw_st3", 32'h0000A183, K_LW,  4'b0010, 1'b1, 1'b0, 3);
        issue("sw",     32'h0020A023, K_SW,  4'b0010, 1'b1, 1'b0, 0);
        issue("sw_st1", 32'h0020A023, K_SW,  4'b0010, 1'b1, 1'b0, 1);
        issue("beq_z1", 32'h00208463, K_BEQ, 4'b0110, 1'b0, 1'b1, 0);
        issue("beq_z0", 32'h00208463, K_BEQ, 4'b0110, 1'b0, 1'b0, 0);
        issue("ill_ff", 32'hFFFFFFFF, K_ILL, 4'b0000, 1'b0, 1'b0, 0);
        issue("sltu",   32'h0020B1B3, K_ILL, 4'b0000, 1'b0, 1'b0, 0);
        issue("sltiu",  32'h0000B093, K_ILL, 4'b0000, 1'b0, 1'b0, 0);
        issue("lb",     32'h00008183, K_ILL, 4'b0000, 1'b0, 1'b0, 0);

        // SW stalled in MEM, then reset lands between clock edges.
        d = rand_drv();
        d.instr = 32'h0020A023;
        push(idle(3'd0), d);
        push(idle(3'd1), rand_drv());
        e = idle(3'd2);
        e.op  = 4'b0010;
        e.src = 1'b1;
        push(e, rand_drv());
        e = idle(3'd3);
        e.wr = 1'b1;
        d = rand_drv();
        d.mrdy = 1'b0;
        push(e, d);
        run_queue("sw_pre_rst");
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check_now("rst_mid_sw_async", idle(3'd0));
        @(posedge clk);
        #1;
        check_now("rst_mid_sw_held", idle(3'd0));
        rst_n = 1'b1;

        issue("add_post_rst", 32'h002081B3, K_R, 4'b0010, 1'b0, 1'b0, 0);
        issue("lw_post_rst",  32'h0000A183, K_LW, 4'b0010, 1'b1, 1'b0, 0);

        @(negedge clk);
        #1;
        check_now("final_fetch", idle(3'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that drives the ALU's `alu_op` port and consumes its `zero` flag. It latches each fetched RV32I instruction and decodes the supported subset: R-type ALU, I-type ALU, LW, SW and BEQ. It sequences FETCH/DECODE/EXEC/MEM/WB and issues the per-state datapath strobes. It sits between instruction memory, the ALU, the register file and data memory.

## Interface
Parameters:
- none; opcodes, ALU op codes and state encodings come from the shared package.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr`  in  32  instruction word, valid throughout FETCH
- `zero`  in  1  ALU zero flag, combinational from current ALU inputs
- `mem_ready`  in  1  data-memory access complete (sampled in MEM)
- `alu_op`  out  4  ALU operation code
- `alu_src`  out  1  0 = rs2 operand, 1 = immediate operand
- `mem_read`  out  1  data-memory read strobe
- `mem_write`  out  1  data-memory write strobe
- `mem_to_reg`  out  1  write-back source: 0 = ALU result register, 1 = memory data
- `reg_write`  out  1  register-file write enable
- `pc_write`  out  1  PC update enable (single-cycle pulse)
- `pc_sel`  out  1  PC source: 0 = PC+4, 1 = branch target
- `illegal`  out  1  unsupported-instruction pulse
- `state`  out  3  current state, for debug

## Operation
- **Register state:** `state` and internal `ir[31:0]`. `ir` is loaded from `instr` on the clock edge that leaves FETCH.
- **Outputs:** all outputs are combinational from `state`, `ir`, `zero` and `mem_ready`. Every strobe is 0 unless listed below. `alu_op` = AND (0000) outside EXEC.
- **FETCH:** no strobes asserted. Next state is always DECODE.
- **DECODE:** classify `ir`.
  - If illegal: `illegal`=1, `pc_write`=1, `pc_sel`=0, next state FETCH.
  - Otherwise next state EXEC.
- **EXEC:** drive `alu_op` and `alu_src`. The datapath captures the ALU result at the end of this state.
  - BEQ: `pc_write`=1, `pc_sel`=`zero`, next state FETCH.
  - LW/SW: next state MEM.
  - R/I: next state WB.
- **MEM:**
  - LW asserts `mem_read`; SW asserts `mem_write`.
  - The strobe is held while `mem_ready`=0 (the controller stays in MEM).
  - When `mem_ready`=1: LW goes to WB; SW asserts `pc_write`=1 with `pc_sel`=0 and goes to FETCH.
- **WB:** `reg_write`=1, `pc_write`=1, `pc_sel`=0. `mem_to_reg`=1 for LW only. Next state FETCH.
- **Decode rules (`ir[6:0]`):**
  - 0110011 R-type, `alu_src`=0, selected by funct3 and `ir[30]`:
    - 000: ADD 0010 when `ir[30]`=0; SUB 0110 when `ir[30]`=1.
    - 111 AND 0000; 110 OR 0001; 100 XOR 0101; 010 SLT 0100; 001 SLL 1001.
    - 101: SRL 1000 when `ir[30]`=0; SRA 1010 when `ir[30]`=1.
    - funct3 011 is illegal.
  - 0010011 I-type, `alu_src`=1: same mapping as R-type except funct3 000 is always ADD. Funct3 011 is illegal.
  - 0000011 LW: requires funct3 010. ADD, `alu_src`=1.
  - 0100011 SW: requires funct3 010. ADD, `alu_src`=1.
  - 1100011 BEQ: requires funct3 000. SUB, `alu_src`=0.
  - Any other opcode or funct3 is illegal.

## Timing
- **Reset:** `rst_n` low forces `state`=FETCH and `ir`=0 immediately, without waiting for a clock edge. All strobes, `illegal` and `pc_sel` read 0, `alu_op`=0000 and `alu_src`=0.
- **Reset mid-operation:** the same applies from any state. An in-flight MEM strobe drops asynchronously, and no `pc_write` or `reg_write` is issued for the aborted instruction.
- **Latency (cycles, with `mem_ready` high on first sample):**
  - R/I: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - Illegal: 2
- Each stall cycle in MEM adds one cycle.
- **`pc_write`:** exactly one cycle per instruction, in the instruction's final state.
- **BEQ:** `zero` is sampled in the same EXEC cycle, with no registering.
- **`ir` stability:** `ir` is stable from DECODE until the next FETCH exit. `instr` is ignored outside FETCH.

## Structure
- **Shared package `cpu_pkg`:**
  - ALU op-code constants, identical values to the ALU's.
  - Opcode constants `OP_RTYPE`, `OP_ITYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`.
  - State enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- **One sub-module, `alu_decode`:** combinational map from `ir` to `alu_op`, `alu_src` and `illegal`. The FSM remains in `multicycle_ctrl`.

## Test plan
- **R-type ADD/SUB:** `instr`=0x002081B3 (add) → EXEC `alu_op`=0010, `alu_src`=0; WB `reg_write`=1, `pc_write`=1; total 4 cycles. Then 0x402081B3 → `alu_op`=0110.
- **I-type shift:** `instr`=0x4020D193 (srai) → EXEC `alu_op`=1010, `alu_src`=1; WB `reg_write`=1.
- **LW with stall:** `instr`=0x0000A183 (lw), `mem_ready` low for 3 MEM cycles → `mem_read` high 4 cycles, then WB `mem_to_reg`=1; total 8 cycles.
- **BEQ both outcomes:** `instr`=0x00208463 (beq) with `zero`=1 in EXEC → `alu_op`=0110, `pc_write`=1, `pc_sel`=1. With `zero`=0 → `pc_sel`=0. Both return to FETCH after 3 cycles.
- **Illegal instructions:** `instr`=0xFFFFFFFF and 0x0020B1B3 (sltu) → DECODE `illegal`=1, `pc_write`=1, `pc_sel`=0; no `reg_write`; FETCH next.
- **Reset mid-SW:** `rst_n` pulsed low while in MEM for SW → `mem_write` falls without a clock edge, `state`=0, no `pc_write`; after release, FETCH proceeds normally.
